cms_trace_packetizer: RTL
=========================

// Module: cms_trace_packetizer
// PURPOSE
//  Parametrised successor to the continuous monitoring packet path: filters the retired
//  pc/instr stream by instruction class, buffers accepted items in an internal FIFO and emits
//  them as AXI-Stream beats with periodic tlast. Sits between the CPU trace port and the DMA FIFO.
//  Adds: class filter, configurable overflow policy (drop+count or CPU stall), counter clear.
// PARAMETERS
//  XLEN                                64  pc width
//  AXI_DATA_WIDTH                      XLEN+32  tdata width; tdata = {instr[31:0], pc[XLEN-1:0]}
//  FIFO_DEPTH                          16  entries, power of 2, >=2
//  CTRL_ADDR_WIDTH                     8   control address width
//  CTRL_DATA_WIDTH                     64  control write data width
//  CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED 1   1: write on 0->1 edge of ctrl_write_enable; 0: every cycle high
// PORTS
//  clk               in   1               single clock, all logic posedge
//  rst_n             in   1               asynchronous, active-low reset
//  instr             in   32              retired instruction
//  pc                in   XLEN            retired pc
//  pc_valid          in   1               instr/pc valid this cycle
//  en                in   1               global enable; 0 = no captures (output drain continues)
//  M_AXIS_tvalid     out  1               stream valid
//  M_AXIS_tready     in   1               stream ready
//  M_AXIS_tdata      out  AXI_DATA_WIDTH  {instr, pc}
//  M_AXIS_tlast      out  1               end of packet
//  tlast_interval    in   32              beats per packet
//  ctrl_addr         in   CTRL_ADDR_WIDTH register address
//  ctrl_wdata        in   CTRL_DATA_WIDTH register data
//  ctrl_write_enable in   1               register write strobe
//  halt_cpu          out  1               stall request (stall mode only)
//  drop_count        out  32              items lost to overflow, saturating
// BEHAVIOUR
//  Reset: tvalid=0, tlast=0, tdata=0, halt_cpu=0, drop_count=0, FIFO empty, beat counter=0,
//   FILTER_MASK=5'h1F, OVF_MODE=0.
//  Regs: 0x01 FILTER_MASK[4:0]; 0x02 OVF_MODE[0] (0 drop, 1 stall); 0x03 CLEAR (any write:
//   drop_count=0, beat counter=0). Other addresses ignored. Edge mode: rising edge detected vs
//   previous-cycle registered strobe, so a held-high strobe causes exactly one write.
//  Class (combinational): bit0 branch opcode 7'b1100011, bit1 jal 7'b1101111, bit2 jalr
//   7'b1100111, bit3 WFI 32'h10500073, bit4 any other. Capture = pc_valid & en & mask[class].
//  Push on captured cycle if FIFO not full, or if full and a pop occurs the same cycle.
//   Otherwise the item is lost: drop_count += 1, saturating at 32'hFFFFFFFF.
//  Latency: item captured at edge N shows on tvalid/tdata after edge N (first-word fall-through
//   from the registered FIFO head). Item order is preserved.
//  AXI: pop when tvalid & tready. tdata/tlast stay stable while tvalid & !tready.
//  tlast: beat counter counts popped beats. tlast=1 on the beat where counter == tlast_interval-1,
//   and the counter returns to 0 on that pop. tlast_interval 0 or 1 -> tlast on every beat.
//   A tlast_interval change takes effect on the next comparison.
//  Stall mode: halt_cpu = (fifo_count >= FIFO_DEPTH-1) registered, leaving one slot for the
//   in-flight retire. Drop counting stays active. Drop mode: halt_cpu=0.
//  OVF_MODE written 1->0 while halted: halt_cpu deasserts next cycle.
//  Simultaneous CLEAR and overflow: CLEAR wins (drop_count=0).
//  en=0 mid-stream: queued items still drain. Async reset mid-transfer discards FIFO contents.
// STRUCTURE
//  cms_pkg: opcode constants, WFI encoding, class bit indices, register addresses, OVF_* enums.
//  Sub-module cms_sync_fifo #(WIDTH, DEPTH): FWFT, full/empty/count, simultaneous push+pop when full.
//  Top holds filter, ctrl regs + edge detect, beat counter, drop counter, halt logic.
// TESTING
//  1 Reset, mask 1F, tready=1, 6 valid items -> 6 beats in order, tdata={instr,pc}, 1-cycle latency.
//  2 FILTER_MASK=5'h01, feed nop/branch/jal/branch -> exactly 2 beats, both opcode 7'h63.
//  3 tlast_interval=3, 7 items, tready=1 -> tlast on beats 3 and 6 only; interval=0 -> tlast on every beat.
//  4 DEPTH=16, tready=0, drop mode, 20 items -> tvalid=1, drop_count=4, head tdata stable;
//    then CLEAR -> drop_count=0.
//  5 OVF_MODE=1, tready=0 -> halt_cpu=1 once count=15; tready=1 -> halt_cpu=0 when count<15.
//  6 ctrl_write_enable held high 5 cycles with CLEAR (edge mode) -> one write. Assert rst_n
//    mid-packet -> all outputs at reset values, next packet starts with beat counter 0.

Source files
------------

// File: rtl/cms_pkg.sv
// Shared constants, register map and instruction classifier for the trace packetizer.
package cms_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] WFI_INSTR = 32'h10500073;

  localparam int unsigned CLS_BRANCH  = 0;
  localparam int unsigned CLS_JAL     = 1;
  localparam int unsigned CLS_JALR    = 2;
  localparam int unsigned CLS_WFI     = 3;
  localparam int unsigned CLS_OTHER   = 4;
  localparam int unsigned NUM_CLASSES = 5;

  localparam int unsigned REG_FILTER_MASK = 32'h01;
  localparam int unsigned REG_OVF_MODE    = 32'h02;
  localparam int unsigned REG_CLEAR       = 32'h03;

  typedef enum logic {
    OVF_DROP  = 1'b0,
    OVF_STALL = 1'b1
  } ovf_mode_e;

  // One-hot class vector; exactly one bit is set for any instruction.
  function automatic logic [NUM_CLASSES-1:0] instr_class(input logic [31:0] instr);
    logic [NUM_CLASSES-1:0] c;
    c = '0;
    if (instr[6:0] == OP_BRANCH)    c[CLS_BRANCH] = 1'b1;
    else if (instr[6:0] == OP_JAL)  c[CLS_JAL]    = 1'b1;
    else if (instr[6:0] == OP_JALR) c[CLS_JALR]   = 1'b1;
    else if (instr == WFI_INSTR)    c[CLS_WFI]    = 1'b1;
    else                            c[CLS_OTHER]  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cms_sync_fifo.sv
// First-word-fall-through synchronous FIFO; accepts a push while full if a pop happens in the same cycle.
module cms_sync_fifo #(
  parameter  int unsigned WIDTH = 96,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gated so the head reads as zero while empty.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cms_trace_packetizer.sv
// Filters the retired pc/instr stream by class, buffers it and emits AXI-Stream beats with periodic tlast.
module cms_trace_packetizer
  import cms_pkg::*;
#(
  parameter int unsigned XLEN                                = 64,
  parameter int unsigned AXI_DATA_WIDTH                      = XLEN + 32,
  parameter int unsigned FIFO_DEPTH                          = 16,
  parameter int unsigned CTRL_ADDR_WIDTH                     = 8,
  parameter int unsigned CTRL_DATA_WIDTH                     = 64,
  parameter int unsigned CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                instr,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic                       en,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                       M_AXIS_tlast,
  input  logic [31:0]                tlast_interval,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  output logic                       halt_cpu,
  output logic [31:0]                drop_count
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam bit          EDGE_MODE = (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0);

  logic                   ctrl_we_q;
  logic                   we_pulse;
  logic                   wr_mask;
  logic                   wr_mode;
  logic                   wr_clear;
  logic [NUM_CLASSES-1:0] filter_mask;
  ovf_mode_e              ovf_mode;
  ovf_mode_e              ovf_mode_d;
  logic                   capture;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [31:0]            beat_cnt;
  logic                   tlast_hit;
  logic                   unused_wdata;

  assign we_pulse     = EDGE_MODE ? (ctrl_write_enable & ~ctrl_we_q) : ctrl_write_enable;
  assign wr_mask      = we_pulse & (ctrl_addr == CTRL_ADDR_WIDTH'(REG_FILTER_MASK));
  assign wr_mode      = we_pulse & (ctrl_addr == CTRL_ADDR_WIDTH'(REG_OVF_MODE));
  assign wr_clear     = we_pulse & (ctrl_addr == CTRL_ADDR_WIDTH'(REG_CLEAR));
  assign unused_wdata = ^ctrl_wdata[CTRL_DATA_WIDTH-1:NUM_CLASSES];

  assign capture = pc_valid & en & |(filter_mask & instr_class(instr));
  assign pop     = M_AXIS_tvalid & M_AXIS_tready;
  assign drop    = capture & fifo_full & ~pop;

  assign M_AXIS_tvalid = ~fifo_empty;
  assign tlast_hit     = (tlast_interval <= 32'd1) || (beat_cnt == tlast_interval - 32'd1);
  assign M_AXIS_tlast  = M_AXIS_tvalid & tlast_hit;

  // Halt looks at the post-write mode so clearing stall mode releases the CPU on the next edge.
  always_comb begin
    ovf_mode_d = ovf_mode;
    if (wr_mode) ovf_mode_d = ovf_mode_e'(ctrl_wdata[0]);
  end

  cms_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   ({instr, pc}),
    .pop   (pop),
    .dout  (M_AXIS_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_we_q   <= 1'b0;
      filter_mask <= '1;
      ovf_mode    <= OVF_DROP;
      halt_cpu    <= 1'b0;
    end else begin
      ctrl_we_q <= ctrl_write_enable;
      if (wr_mask) filter_mask <= ctrl_wdata[NUM_CLASSES-1:0];
      ovf_mode <= ovf_mode_d;
      halt_cpu <= (ovf_mode_d == OVF_STALL) && (fifo_count >= CW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      drop_count <= '0;
    end else begin
      if (wr_clear)  beat_cnt <= '0;
      else if (pop)  beat_cnt <= tlast_hit ? '0 : beat_cnt + 32'd1;
      if (wr_clear)  drop_count <= '0;
      else if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end

endmodule
